nreg_write_arbiter: RTL
=======================

Name: nreg_write_arbiter

Overview:
- Shares one enabled N-bit register (data in, write-enable in, Q out) among NREQ requesters.
- Arbitrates requests round-robin, latches the winner's data, and drives the register's D and enable for exactly one cycle per grant.
- Acknowledges the winning requester and applies an optional hold-off gap between writes.
- Sits between the requesting datapath blocks and the shared register instance.

Parameters:
- WIDTH, 8, data width of the shared register.
- NREQ, 4, number of requesters; must be 2 or more.
- HOLD_CYCLES, 1, idle cycles forced after each write; 0..15 allowed.

Ports:
- clk  input  1  single clock; rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_req_valid  input  NREQ  bit i high means requester i wants to write.
- io_req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- io_req_ready  output  NREQ  one-hot, one-cycle acknowledge of the accepted request.
- io_reg_D  output  WIDTH  data to the shared register.
- io_reg_enable  output  1  write-enable to the shared register.
- io_owner  output  clog2(NREQ)  index of the last granted requester.
- io_busy  output  1  high in WRITE or HOLD.
- io_write_count  output  8  number of completed writes; wraps 255->0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, ptr=0, latched data=0, owner=0, count=0, hold counter=0.
  - All outputs 0 immediately, without waiting for a clock edge.
- States: IDLE, WRITE, HOLD.
- IDLE:
  - On each edge, if any io_req_valid bit is set, pick the first set index scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - Latch that index into owner and its data slice into the data register; go to WRITE.
  - If no valid bit is set, stay in IDLE.
- WRITE (exactly 1 cycle):
  - io_reg_enable=1, io_reg_D=latched data, io_req_ready[owner]=1, all other ready bits 0.
  - On the edge ending WRITE: count+=1; ptr=(owner+1) mod NREQ.
  - Next state is HOLD with counter=HOLD_CYCLES, or IDLE when HOLD_CYCLES=0.
- HOLD:
  - Outputs idle. Counter decrements each edge; go to IDLE on the edge where it reaches 0.
  - Gives exactly HOLD_CYCLES cycles in HOLD.
- Latency: valid sampled at edge t; enable and ready are high in the cycle following edge t.
  - Minimum period per write is 2+HOLD_CYCLES cycles.
- io_reg_D holds its last value when enable=0. io_reg_enable, io_req_ready and io_busy are decoded from the registered state only.
- Handshake:
  - A requester keeps valid and data stable until it sees its ready bit.
  - Valid is sampled only in IDLE.
  - A requester dropping valid after being latched still gets its write and ack (data already captured).
- Simultaneous requests: only one grant per arbitration, and no requester is skipped twice in a row.
  - With all valid bits held high, grants rotate ptr, ptr+1, ...
- ptr wraps NREQ-1 -> 0.
- Valid changes during WRITE or HOLD have no effect until the next IDLE cycle.
- Reset asserted mid-WRITE:
  - enable and ready drop asynchronously.
  - The write is not counted and ptr is not advanced.
  - The arbiter restarts from IDLE with ptr=0 after reset deasserts.
- io_busy=0 only in IDLE.

Test Plan:
1. Reset with reset=0 and random inputs -> io_reg_enable=0, io_req_ready=0000, io_owner=0, io_write_count=0, io_busy=0. Release reset with valid=0000 -> outputs stay 0.
2. valid=0010, data1=0xA5 for one edge -> next cycle enable=1, D=0xA5, ready=0010, owner=1, busy=1. Then 1 HOLD cycle, then IDLE with count=1.
3. All four valid continuously, data 0x10/0x11/0x12/0x13 (HOLD_CYCLES=1) -> writes 0x10, 0x11, 0x12, 0x13, 0x10 every 3 cycles, ready one-hot each time, count=5.
4. With ptr=2 (after a grant to 1), valid=1010 -> grant 3, then grant 1. ptr wraps to 0 after the grant to 3; count increments by 2.
5. Assert reset during a WRITE cycle -> enable and ready go 0 before the next edge, count unchanged from 0 after reset. Re-request on valid=1000 -> grant 3 as first index found from ptr=0.
6. HOLD_CYCLES=0, valid=0001 held, data0 incrementing each grant -> enable pulses every 2 cycles, IDLE/WRITE alternating, count increments by 1 per pulse, 255->0 wrap checked after 256 writes.

Source files
------------

// File: rtl/nreg_write_arbiter.sv
// rtl/nreg_write_arbiter.sv - round-robin write arbiter for one shared enabled register
module nreg_write_arbiter #(
    parameter int WIDTH       = 8,
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         io_req_valid,
    input  logic [NREQ*WIDTH-1:0]   io_req_data,
    output logic [NREQ-1:0]         io_req_ready,
    output logic [WIDTH-1:0]        io_reg_D,
    output logic                    io_reg_enable,
    output logic [$clog2(NREQ)-1:0] io_owner,
    output logic                    io_busy,
    output logic [7:0]              io_write_count
);

    localparam int OW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       r_state;
    logic [OW-1:0]    r_ptr;
    logic [OW-1:0]    r_owner;
    logic [WIDTH-1:0] r_data;
    logic [7:0]       r_count;
    logic [3:0]       r_hold;

    logic             w_found;
    logic [OW-1:0]    w_pick;
    logic [OW-1:0]    w_ptr_next;
    int               w_idx;

    // First valid requester at or after r_ptr, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && io_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx[OW-1:0];
            end
        end
    end

    assign w_ptr_next = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_data  <= io_req_data[int'(w_pick)*WIDTH +: WIDTH];
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_count <= r_count + 8'd1;
                    r_ptr   <= w_ptr_next;
                    if (HOLD_CYCLES == 0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_HOLD;
                        r_hold  <= 4'(HOLD_CYCLES);
                    end
                end
                S_HOLD: begin
                    // Leave on the edge where the counter would reach zero.
                    r_hold <= r_hold - 4'd1;
                    if (r_hold <= 4'd1) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_reg_enable  = (r_state == S_WRITE);
    assign io_req_ready   = io_reg_enable ? (NREQ'(1) << r_owner) : '0;
    assign io_reg_D       = r_data;
    assign io_owner       = r_owner;
    assign io_busy        = (r_state != S_IDLE);
    assign io_write_count = r_count;

endmodule
